vga_timing_gen: RTL and testbench

//  Raster timing source for the VGA display path. Free-running pixel/line counters generate
//  VGA_horzCoord/VGA_vertCoord, HSYNC/VSYNC, active-video flag and frame/line strobes.

---
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters with registered coords, syncs, active flag and strobes.
// Optional macro VGA_PIPE_ALIGN_EN delays HS/VS/ACTIVE by PIPE_DLY enabled pixels.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int PIPE_DLY = 2
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  input  logic        PIX_CE,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_ACTIVE,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        FRAME_START,
  output logic        LINE_END
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        H_ASSERT   = (H_POL != 0);
  localparam logic        V_ASSERT   = (V_POL != 0);

  // Reject configurations the 12-bit counters cannot represent.
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 4096");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_width
    $error("vga_timing_gen: timing width parameter is zero");
  end
  if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY outside 1..8");
  end

  logic [11:0] horz_reg, vert_reg;
  logic [11:0] horz_next, vert_next;
  logic        act_reg, hs_reg, vs_reg;
  logic        act_next, hs_next, vs_next;
  logic        frame_start_reg, line_end_reg;
  logic        line_wrap;

  // Flags decode from the next coordinates so they register alongside them.
  always_comb begin
    line_wrap = (horz_reg == H_LAST);
    horz_next = line_wrap ? 12'd0 : horz_reg + 12'd1;
    vert_next = vert_reg;
    if (line_wrap) begin
      vert_next = (vert_reg == V_LAST) ? 12'd0 : vert_reg + 12'd1;
    end
    act_next = (horz_next < H_ACT_END) && (vert_next < V_ACT_END);
    hs_next  = ((horz_next >= HS_START) && (horz_next < HS_END)) ? H_ASSERT : ~H_ASSERT;
    vs_next  = ((vert_next >= VS_START) && (vert_next < VS_END)) ? V_ASSERT : ~V_ASSERT;
  end

  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      horz_reg        <= H_LAST;
      vert_reg        <= V_LAST;
      act_reg         <= 1'b0;
      hs_reg          <= ~H_ASSERT;
      vs_reg          <= ~V_ASSERT;
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
    end else if (PIX_CE) begin
      horz_reg        <= horz_next;
      vert_reg        <= vert_next;
      act_reg         <= act_next;
      hs_reg          <= hs_next;
      vs_reg          <= vs_next;
      frame_start_reg <= (horz_next == 12'd0) && (vert_next == 12'd0);
      line_end_reg    <= (horz_next == H_LAST);
    end else begin
      // Strobes mark a single enabled pixel; they never stretch across stalls.
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
    end
  end

  assign VGA_horzCoord = horz_reg;
  assign VGA_vertCoord = vert_reg;
  assign FRAME_START   = frame_start_reg;
  assign LINE_END      = line_end_reg;

`ifdef VGA_PIPE_ALIGN_EN
  localparam logic [2:0] STAGE_IDLE = {1'b0, ~V_ASSERT, ~H_ASSERT};

  // Each stage holds {active, vs, hs}; the chain only moves on enabled pixels.
  for (genvar gi = 0; gi < PIPE_DLY; gi++) begin : g_stage
    logic [2:0] stage_reg;
    logic [2:0] stage_in;
    if (gi == 0) begin : g_head
      assign stage_in = {act_reg, vs_reg, hs_reg};
    end else begin : g_tail
      assign stage_in = g_stage[gi-1].stage_reg;
    end
    always_ff @(posedge CLK_VGA or posedge RESET) begin
      if (RESET) begin
        stage_reg <= STAGE_IDLE;
      end else if (PIX_CE) begin
        stage_reg <= stage_in;
      end
    end
  end

  assign {VGA_ACTIVE, VGA_VS, VGA_HS} = g_stage[PIPE_DLY-1].stage_reg;
`else
  assign VGA_ACTIVE = act_reg;
  assign VGA_HS     = hs_reg;
  assign VGA_VS     = vs_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-size raster for line/gating/reset checks, a small raster for whole frames.
module tb_vga_timing_gen;

  localparam int SH_TOTAL = 16;
  localparam int SV_TOTAL = 11;
  localparam int S_FRAME  = SH_TOTAL * SV_TOTAL;
`ifdef VGA_PIPE_ALIGN_EN
  localparam int PD = 2;
`else
  localparam int PD = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic [11:0] a_h, a_v, b_h, b_v;
  logic a_act, a_hs, a_vs, a_fs, a_le;
  logic b_act, b_hs, b_vs, b_fs, b_le;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .CLK_VGA(clk), .RESET(rst), .PIX_CE(ce),
    .VGA_horzCoord(a_h), .VGA_vertCoord(a_v), .VGA_ACTIVE(a_act),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .FRAME_START(a_fs), .LINE_END(a_le)
  );

  // 16 x 11 raster, active-low HSYNC: visible 8x6, HS on h 10..12, VS on lines 7..8.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(0), .V_POL(1), .PIPE_DLY(2)
  ) dut_b (
    .CLK_VGA(clk), .RESET(rst), .PIX_CE(ce),
    .VGA_horzCoord(b_h), .VGA_vertCoord(b_v), .VGA_ACTIVE(b_act),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .FRAME_START(b_fs), .LINE_END(b_le)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ce  = 1'b1;
    step;
    step;
    checks++; if (a_h !== 12'd1687) begin failures++; $display("FAIL reset_horz got=%0d exp=1687", a_h); end
    checks++; if (a_v !== 12'd1065) begin failures++; $display("FAIL reset_vert got=%0d exp=1065", a_v); end
    checks++; if (a_act !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", a_act); end
    checks++; if (a_hs !== 1'b0 || a_vs !== 1'b0) begin failures++; $display("FAIL reset_sync got=hs%b vs%b exp=hs0 vs0", a_hs, a_vs); end
    checks++; if (a_fs !== 1'b0 || a_le !== 1'b0) begin failures++; $display("FAIL reset_strobe got=fs%b le%b exp=fs0 le0", a_fs, a_le); end
    checks++; if (b_h !== 12'd15 || b_v !== 12'd10) begin failures++; $display("FAIL reset_small_coord got=(%0d,%0d) exp=(15,10)", b_h, b_v); end
    checks++; if (b_hs !== 1'b1) begin failures++; $display("FAIL reset_small_hs_inactive got=%b exp=1", b_hs); end
    rst = 1'b0;
    step;
    checks++; if (a_h !== 12'd0 || a_v !== 12'd0) begin failures++; $display("FAIL first_coord got=(%0d,%0d) exp=(0,0)", a_h, a_v); end
    checks++; if (a_fs !== 1'b1) begin failures++; $display("FAIL first_frame_start got=%b exp=1", a_fs); end
    checks++; if (a_act !== (PD == 0)) begin failures++; $display("FAIL first_active got=%b exp=%b", a_act, (PD == 0)); end
    checks++; if (a_hs !== 1'b0 || a_vs !== 1'b0 || a_le !== 1'b0) begin failures++; $display("FAIL first_levels got=hs%b vs%b le%b exp=0 0 0", a_hs, a_vs, a_le); end
    $display("test_reset: coord=(%0d,%0d) fs=%b act=%b", a_h, a_v, a_fs, a_act);
  endtask

  task automatic test_line;
    int le_n = 0, le_h = -1, hs_n = 0, hs_first = -1, act_n = 0, act_fall = -1, coord_bad = 0;
    logic prev_act;
    prev_act = a_act;
    for (int i = 0; i < 1688; i++) begin
      if (a_h !== 12'(i) || a_v !== 12'd0) coord_bad++;
      if (a_le === 1'b1) begin le_n++; le_h = int'(a_h); end
      if (a_hs === 1'b1) begin hs_n++; if (hs_first < 0) hs_first = int'(a_h); end
      if (a_act === 1'b1) act_n++;
      if (prev_act === 1'b1 && a_act === 1'b0 && act_fall < 0) act_fall = int'(a_h);
      prev_act = a_act;
      step;
    end
    checks++; if (coord_bad != 0) begin failures++; $display("FAIL line_coords got=%0d_bad exp=0_bad", coord_bad); end
    checks++; if (a_h !== 12'd0 || a_v !== 12'd1) begin failures++; $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", a_h, a_v); end
    checks++; if (a_fs !== 1'b0 || a_le !== 1'b0) begin failures++; $display("FAIL line_wrap_strobes got=fs%b le%b exp=0 0", a_fs, a_le); end
    checks++; if (le_n != 1 || le_h != 1687) begin failures++; $display("FAIL line_end got=n%0d@%0d exp=n1@1687", le_n, le_h); end
    checks++; if (hs_n != 112) begin failures++; $display("FAIL hs_width got=%0d exp=112", hs_n); end
    checks++; if (hs_first != 1328 + PD) begin failures++; $display("FAIL hs_start got=%0d exp=%0d", hs_first, 1328 + PD); end
    checks++; if (act_n != 1280) begin failures++; $display("FAIL line_active_count got=%0d exp=1280", act_n); end
    checks++; if (act_fall != 1280 + PD) begin failures++; $display("FAIL active_fall got=%0d exp=%0d", act_fall, 1280 + PD); end
    $display("test_line: le=%0d@%0d hs=%0d from %0d act=%0d fall=%0d", le_n, le_h, hs_n, hs_first, act_n, act_fall);
  endtask

  task automatic test_ce_gate;
    int n = 0;
    logic [11:0] v0;
    ce = 1'b1;
    while (a_h !== 12'd1686 && n < 4000) begin step; n++; end
    checks++; if (a_h !== 12'd1686) begin failures++; $display("FAIL ce_reach_1686 got=%0d exp=1686", a_h); end
    v0 = a_v;
    step;
    checks++; if (a_h !== 12'd1687 || a_le !== 1'b1) begin failures++; $display("FAIL ce_edge1 got=h%0d le%b exp=h1687 le1", a_h, a_le); end
    ce = 1'b0;
    step;
    checks++; if (a_h !== 12'd1687 || a_v !== v0 || a_le !== 1'b0) begin failures++; $display("FAIL ce_hold1 got=(%0d,%0d) le%b exp=(1687,%0d) le0", a_h, a_v, a_le, v0); end
    step;
    checks++; if (a_h !== 12'd1687 || a_v !== v0 || a_le !== 1'b0) begin failures++; $display("FAIL ce_hold2 got=(%0d,%0d) le%b exp=(1687,%0d) le0", a_h, a_v, a_le, v0); end
    ce = 1'b1;
    step;
    checks++; if (a_h !== 12'd0 || a_v !== v0 + 12'd1 || a_le !== 1'b0) begin failures++; $display("FAIL ce_wrap got=(%0d,%0d) le%b exp=(0,%0d) le0", a_h, a_v, a_le, v0 + 12'd1); end
    $display("test_ce_gate: wrap to (%0d,%0d) after two held cycles", a_h, a_v);
  endtask

  task automatic test_frame;
    int coord_bad = 0, fs_bad = 0, fs_n = 0, vs_bad = 0, vs_n = 0, hs_bad = 0, hs_n = 0;
    int act_bad = 0, act_n = 0, le_bad = 0, kd, ln;
    logic e_vs, e_hs, e_act;
    rst = 1'b1;
    ce  = 1'b1;
    step;
    rst = 1'b0;
    for (int k = 0; k < 2 * S_FRAME; k++) begin
      step;
      kd = k - PD;
      ln = (kd / SH_TOTAL) % SV_TOTAL;
      e_vs  = (kd >= 0) && (ln >= 7) && (ln <= 8);
      e_hs  = !((kd >= 0) && (kd % SH_TOTAL >= 10) && (kd % SH_TOTAL <= 12));
      e_act = (kd >= 0) && (kd % SH_TOTAL < 8) && (ln < 6);
      if (b_h !== 12'(k % SH_TOTAL) || b_v !== 12'((k / SH_TOTAL) % SV_TOTAL)) coord_bad++;
      if (b_fs !== (k % S_FRAME == 0)) fs_bad++;
      if (b_le !== (k % SH_TOTAL == SH_TOTAL - 1)) le_bad++;
      if (b_vs !== e_vs) vs_bad++;
      if (b_hs !== e_hs) hs_bad++;
      if (b_act !== e_act) act_bad++;
      if (b_fs === 1'b1) fs_n++;
      if (b_vs === 1'b1) vs_n++;
      if (b_hs === 1'b0) hs_n++;
      if (b_act === 1'b1) act_n++;
    end
    checks++; if (coord_bad != 0) begin failures++; $display("FAIL frame_coords got=%0d_bad exp=0_bad", coord_bad); end
    checks++; if (fs_bad != 0 || fs_n != 2) begin failures++; $display("FAIL frame_start_period got=bad%0d n%0d exp=bad0 n2", fs_bad, fs_n); end
    checks++; if (le_bad != 0) begin failures++; $display("FAIL frame_line_end got=%0d_bad exp=0_bad", le_bad); end
    checks++; if (vs_bad != 0 || vs_n != 64) begin failures++; $display("FAIL frame_vs got=bad%0d n%0d exp=bad0 n64", vs_bad, vs_n); end
    checks++; if (hs_bad != 0 || hs_n != 66) begin failures++; $display("FAIL frame_hs_low got=bad%0d n%0d exp=bad0 n66", hs_bad, hs_n); end
    checks++; if (act_bad != 0 || act_n != 96) begin failures++; $display("FAIL frame_active got=bad%0d n%0d exp=bad0 n96", act_bad, act_n); end
    $display("test_frame: fs=%0d vs=%0d hs_low=%0d act=%0d over two frames", fs_n, vs_n, hs_n, act_n);
  endtask

  task automatic test_strobe_gate;
    ce = 1'b1;
    step;
    checks++; if (b_h !== 12'd0 || b_v !== 12'd0 || b_fs !== 1'b1) begin failures++; $display("FAIL sg_frame_start got=(%0d,%0d) fs%b exp=(0,0) fs1", b_h, b_v, b_fs); end
    ce = 1'b0;
    step;
    checks++; if (b_h !== 12'd0 || b_v !== 12'd0 || b_fs !== 1'b0) begin failures++; $display("FAIL sg_hold1 got=(%0d,%0d) fs%b exp=(0,0) fs0", b_h, b_v, b_fs); end
    step;
    checks++; if (b_fs !== 1'b0) begin failures++; $display("FAIL sg_hold2 got=fs%b exp=fs0", b_fs); end
    ce = 1'b1;
    step;
    checks++; if (b_h !== 12'd1 || b_fs !== 1'b0) begin failures++; $display("FAIL sg_resume got=h%0d fs%b exp=h1 fs0", b_h, b_fs); end
    $display("test_strobe_gate: frame strobe not stretched over stall");
  endtask

  task automatic test_async_reset;
    int n = 0;
    rst = 1'b1;
    ce  = 1'b1;
    step;
    rst = 1'b0;
    step;
    while (!(a_h === 12'd700 && a_v === 12'd1) && n < 3000) begin step; n++; end
    checks++; if (a_h !== 12'd700 || a_v !== 12'd1) begin failures++; $display("FAIL ar_reach got=(%0d,%0d) exp=(700,1)", a_h, a_v); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (a_h !== 12'd1687 || a_v !== 12'd1065) begin failures++; $display("FAIL ar_async_coord got=(%0d,%0d) exp=(1687,1065)", a_h, a_v); end
    checks++; if (a_act !== 1'b0 || a_hs !== 1'b0 || a_vs !== 1'b0 || a_fs !== 1'b0 || a_le !== 1'b0) begin
      failures++; $display("FAIL ar_async_flags got=act%b hs%b vs%b fs%b le%b exp=0 0 0 0 0", a_act, a_hs, a_vs, a_fs, a_le);
    end
    step;
    checks++; if (a_h !== 12'd1687) begin failures++; $display("FAIL ar_held got=%0d exp=1687", a_h); end
    rst = 1'b0;
    step;
    checks++; if (a_h !== 12'd0 || a_v !== 12'd0 || a_fs !== 1'b1) begin failures++; $display("FAIL ar_restart got=(%0d,%0d) fs%b exp=(0,0) fs1", a_h, a_v, a_fs); end
    $display("test_async_reset: restart at (%0d,%0d)", a_h, a_v);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ce  = 1'b0;
    test_reset;
    test_line;
    test_ce_gate;
    test_frame;
    test_strobe_gate;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
